// File: rtl/rc_sampler_if.sv
// rc_sampler_if: XOF word stream in, packed Z_q vector out.
interface rc_sampler_if #(
    parameter int BITLEN  = 17,
    parameter int PASTA_S = 32,
    parameter int XOF_W   = 64
);
    logic [XOF_W-1:0]          xof_data;
    logic                      xof_valid;
    logic                      xof_ready;
    logic [BITLEN*PASTA_S-1:0] vec_out;
    logic                      vec_valid;
    logic                      vec_ready;
    modport master (output xof_data, xof_valid, vec_ready, input xof_ready, vec_out, vec_valid);
    modport slave  (input xof_data, xof_valid, vec_ready, output xof_ready, vec_out, vec_valid);
endinterface

// File: rtl/rc_sampler.sv
// rc_sampler: rejection-samples XOF words into Z_q and emits double-buffered vectors.
// Define RCS_NONZERO_EN to also reject zero candidates (Z_q* sampling).
module rc_sampler #(
    parameter int BITLEN  = 17,
    parameter int Q       = 65537,
    parameter int PASTA_S = 32,
    parameter int XOF_W   = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_rcs,
    input  logic             start_rcs,
    input  logic [7:0]       nvec_rcs,
    rc_sampler_if.slave      bus,
    output logic             busy_rcs,
    output logic             done_rcs,
    output logic [CNT_W-1:0] rej_cnt
);
    typedef enum logic [2:0] {IDLE, FILL, XFER, DRAIN, DONE} state_t;
    localparam int IDX_W = $clog2(PASTA_S);
    localparam logic [BITLEN-1:0] Q_V = BITLEN'(Q);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PASTA_S - 1);
    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [7:0]                rem_q, rem_d;
    logic [BITLEN*PASTA_S-1:0] fill_q, fill_d, vec_q, vec_d;
    logic                      vec_valid_q, vec_valid_d;
    logic [CNT_W-1:0]          rej_q, rej_d;
    logic [BITLEN-1:0]         cand;
    logic                      accept, out_free;
    always_comb begin
        cand = bus.xof_data[BITLEN-1:0];
`ifdef RCS_NONZERO_EN
        accept = cand < Q_V && cand != '0;
`else
        accept = cand < Q_V;
`endif
        out_free    = !vec_valid_q || bus.vec_ready;
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        fill_d      = fill_q;
        vec_d       = vec_q;
        rej_d       = rej_q;
        vec_valid_d = vec_valid_q && !bus.vec_ready;
        case (state_q)
            IDLE: if (start_rcs) begin
                rem_d   = nvec_rcs;
                rej_d   = '0;
                state_d = nvec_rcs == 8'd0 ? DONE : FILL;
            end
            FILL: if (bus.xof_valid) begin
                if (accept) begin
                    fill_d[BITLEN*idx_q +: BITLEN] = cand;
                    idx_d   = idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
                    state_d = idx_q == IDX_LAST ? XFER : FILL;
                end else begin
                    rej_d = rej_q + CNT_W'(rej_q != '1);
                end
            end
            // fill buffer moves out only when the output slot is empty or being taken
            XFER: if (out_free) begin
                vec_d       = fill_q;
                vec_valid_d = 1'b1;
                rem_d       = rem_q - 8'd1;
                state_d     = rem_q > 8'd1 ? FILL : DRAIN;
            end
            DRAIN:   state_d = vec_valid_q && bus.vec_ready ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_rcs) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rem_q       <= '0;
            fill_q      <= '0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            rej_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            fill_q      <= fill_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            rej_q       <= rej_d;
        end
    end
    assign bus.xof_ready = state_q == FILL;
    assign bus.vec_out   = vec_q;
    assign bus.vec_valid = vec_valid_q;
    assign busy_rcs      = state_q != IDLE;
    assign done_rcs      = state_q == DONE;
    assign rej_cnt       = rej_q;
endmodule

// File: tb/tb_rc_sampler.sv
// tb_rc_sampler: directed table and sequence checks for rc_sampler.
module tb_rc_sampler;
`ifdef RCS_NONZERO_EN
    localparam int NZ = 1;
`else
    localparam int NZ = 0;
`endif
    logic        clk = 1'b0;
    logic        rst_rcs, start_rcs, busy_rcs, done_rcs;
    logic [7:0]  nvec_rcs;
    logic [15:0] rej_cnt;
    always #5 clk = ~clk;
    rc_sampler_if bus();
    rc_sampler dut (.clk(clk), .rst_rcs(rst_rcs), .start_rcs(start_rcs), .nvec_rcs(nvec_rcs),
                    .bus(bus), .busy_rcs(busy_rcs), .done_rcs(done_rcs), .rej_cnt(rej_cnt));
    typedef struct {
        logic [63:0] word;
        int          rej;
        int          idx;
        logic [16:0] val;
    } row_t;
    row_t tbl [40];
    int   n, tests = 0, fails = 0;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [16:0] el(input int i);
        return bus.vec_out[17*i +: 17];
    endfunction
    task automatic start(input logic [7:0] nv);
        nvec_rcs  = nv;
        start_rcs = 1'b1;
        step;
        start_rcs = 1'b0;
    endtask
    task automatic push(input logic [63:0] w);
        bit got = 0;
        bus.xof_valid = 1'b1;
        bus.xof_data  = w;
        for (int c = 0; c < 300 && !got; c++) begin
            got = bus.xof_ready;
            step;
        end
        bus.xof_valid = 1'b0;
        if (!got) chk("push_timeout", 0, 1);
    endtask
    task automatic run_table(input string nm);
        bus.vec_ready = 1'b1;
        start(8'd1);
        for (int i = 0; i < n; i++) begin
            chk({nm, "_ready"}, bus.xof_ready, 1);
            bus.xof_valid = 1'b1;
            bus.xof_data  = tbl[i].word;
            step;
            chk({nm, "_rej"}, rej_cnt, tbl[i].rej);
        end
        bus.xof_valid = 1'b0;
        chk({nm, "_xfer_novalid"}, bus.vec_valid, 0);
        chk({nm, "_xfer_noready"}, bus.xof_ready, 0);
        step;
        chk({nm, "_valid"}, bus.vec_valid, 1);
        for (int i = 0; i < n; i++)
            if (tbl[i].idx >= 0) chk({nm, "_elem"}, el(tbl[i].idx), tbl[i].val);
        step;
        chk({nm, "_done"}, done_rcs, 1);
        chk({nm, "_valid_drop"}, bus.vec_valid, 0);
        step;
        chk({nm, "_done_pulse"}, done_rcs, 0);
        chk({nm, "_idle"}, busy_rcs, 0);
        chk({nm, "_rej_hold"}, rej_cnt, tbl[n-1].rej);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int got, dcnt;
        bit seen_done, seen_rdy, seen_vld;
        rst_rcs = 1'b0; start_rcs = 1'b0; nvec_rcs = '0;
        bus.xof_valid = 1'b0; bus.xof_data = '0; bus.vec_ready = 1'b0;
        step; step;
        chk("rst_busy", busy_rcs, 0);
        chk("rst_done", done_rcs, 0);
        chk("rst_xof_ready", bus.xof_ready, 0);
        chk("rst_vec_valid", bus.vec_valid, 0);
        chk("rst_rej", rej_cnt, 0);
        rst_rcs = 1'b1;
        step;
        // words 0..31; a zero word is an extra rejection when nonzero sampling is on
        for (int i = 0; i < 32 + NZ; i++) tbl[i] = '{64'(i), NZ, i - NZ, 17'(i)};
        n = 32 + NZ;
        run_table("t1");
        tbl[0] = '{64'd65537, 1, -1, 17'd0};
        tbl[1] = '{64'h1FFFF, 2, -1, 17'd0};
        tbl[2] = '{64'hFFFF_FFFF_0001_0000, 2, 0, 17'd65536};
        for (int i = 1; i < 32; i++) tbl[i+2] = '{64'hFFFF_0000_0000_0000 | 64'(3*i), 2, i, 17'(3*i)};
        n = 34;
        run_table("t2");
        bus.vec_ready = 1'b0;
        start(8'd3);
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < 32; i++) push(64'((v + 1) * 1000 + i));
        for (int c = 0; c < 4; c++) begin
            chk("t3_stall_noready", bus.xof_ready, 0);
            step;
        end
        chk("t3_held_valid", bus.vec_valid, 1);
        chk("t3_held_e0", el(0), 1000);
        chk("t3_held_e31", el(31), 1031);
        bus.vec_ready = 1'b1;
        got = 0;
        seen_done = 0;
        fork
            for (int i = 0; i < 32; i++) push(64'(3000 + i));
            for (int c = 0; c < 400 && !seen_done; c++) begin
                if (bus.vec_valid) begin
                    chk("t3_order_e0", el(0), 17'((got + 1) * 1000));
                    chk("t3_order_e31", el(31), 17'((got + 1) * 1000 + 31));
                    got++;
                end
                if (done_rcs) seen_done = 1;
                step;
            end
        join
        chk("t3_vec_count", got, 3);
        chk("t3_done", seen_done, 1);
        step;
        start(8'd0);
        dcnt = 0; seen_rdy = 0; seen_vld = 0;
        for (int c = 0; c < 5; c++) begin
            dcnt += int'(done_rcs);
            seen_rdy |= bus.xof_ready;
            seen_vld |= bus.vec_valid;
            step;
        end
        chk("t4_done_once", dcnt, 1);
        chk("t4_no_ready", seen_rdy, 0);
        chk("t4_no_valid", seen_vld, 0);
        chk("t4_idle", busy_rcs, 0);
        start(8'd1);
        push(64'h1FFFF);
        for (int i = 0; i < 10; i++) push(64'(100 + i));
        chk("t5_pre_rej", rej_cnt, 1);
        chk("t5_pre_busy", busy_rcs, 1);
        rst_rcs = 1'b0;
        bus.xof_valid = 1'b1;
        bus.xof_data  = 64'd110;
        step;
        bus.xof_valid = 1'b0;
        chk("t5_busy", busy_rcs, 0);
        chk("t5_done", done_rcs, 0);
        chk("t5_ready", bus.xof_ready, 0);
        chk("t5_valid", bus.vec_valid, 0);
        chk("t5_rej", rej_cnt, 0);
        chk("t5_vec_zero", |bus.vec_out, 0);
        rst_rcs = 1'b1;
        step;
        start(8'd1);
        for (int i = 0; i < 32; i++) push(64'(200 + i));
        step;
        chk("t5_new_valid", bus.vec_valid, 1);
        chk("t5_new_e0", el(0), 200);
        chk("t5_new_e10", el(10), 210);
        chk("t5_new_e31", el(31), 231);
        step;
        chk("t5_new_done", done_rcs, 1);
        step;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
